// File: rtl/echo_pkg.sv
// Shared types and helpers for the echo_queue request/indication buffer.
package echo_pkg;

  typedef enum logic {
    SAY  = 1'b0,
    SAY2 = 1'b1
  } msg_type_t;

  // A zero DELAY still needs a legal (1-bit) vector width where an age is declared.
  function automatic int age_width(input int delay);
    return (delay <= 0) ? 1 : $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/echo_sync_fifo.sv
// Generic DEPTH x W synchronous FIFO with an explicit occupancy count.
module echo_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; validity is defined by the count alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/echo_queue.sv
// Buffers say/say2 requests in a FIFO and replays them as heard/heard2 after a head residency.
module echo_queue
  import echo_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int HALF_W = DATA_W / 2,
  parameter int DELAY  = 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   request_say__ENA,
  input  logic [DATA_W-1:0]      request_say_v,
  output logic                   request_say__RDY,
  input  logic                   request_say2__ENA,
  input  logic [HALF_W-1:0]      request_say2_a,
  input  logic [HALF_W-1:0]      request_say2_b,
  output logic                   request_say2__RDY,
  input  logic                   request_setLeds__ENA,
  input  logic [7:0]             request_setLeds_v,
  output logic                   request_setLeds__RDY,
  output logic                   indication_heard__ENA,
  output logic [DATA_W-1:0]      indication_heard_v,
  input  logic                   indication_heard__RDY,
  output logic                   indication_heard2__ENA,
  output logic [HALF_W-1:0]      indication_heard2_a,
  output logic [HALF_W-1:0]      indication_heard2_b,
  input  logic                   indication_heard2__RDY,
  output logic [7:0]             leds,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  localparam int ENT_W = DATA_W + 1;

  typedef struct packed {
    msg_type_t             mtype;
    logic [DATA_W-1:0]     payload;
  } echo_entry_t;

  echo_entry_t      wr_entry, head;
  logic [ENT_W-1:0] head_bits;
  logic             full, empty, push, pop, aged, eligible, any_ena;
  logic             err_q, err_d;
  logic [7:0]       leds_q, leds_d;

  echo_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head_bits),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign head = echo_entry_t'(head_bits);

  // A concurrent say wins over say2, so the write mux only looks at say__ENA.
  always_comb begin
    wr_entry.mtype   = SAY;
    wr_entry.payload = request_say_v;
    if (!request_say__ENA) begin
      wr_entry.mtype   = SAY2;
      wr_entry.payload = {request_say2_b, request_say2_a};
    end
  end

  assign any_ena              = request_say__ENA || request_say2__ENA;
  assign request_say__RDY     = !full;
  assign request_say2__RDY    = !full;
  assign request_setLeds__RDY = 1'b1;
  assign push                 = !full && any_ena;

  assign eligible               = !empty && aged;
  assign indication_heard__ENA  = eligible && (head.mtype == SAY) && indication_heard__RDY;
  assign indication_heard2__ENA = eligible && (head.mtype == SAY2) && indication_heard2__RDY;
  assign pop                    = indication_heard__ENA || indication_heard2__ENA;

  assign indication_heard_v  = head.payload;
  assign indication_heard2_a = head.payload[HALF_W-1:0];
  assign indication_heard2_b = head.payload[DATA_W-1:HALF_W];

  if (DELAY == 0) begin : g_no_wait
    assign aged = 1'b1;
  end else begin : g_age
    localparam int AGE_W = age_width(DELAY);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(DELAY);
    logic [AGE_W-1:0] age_q, age_d;

    // Age restarts whenever a different entry becomes the head.
    always_comb begin
      age_d = age_q;
      if (pop || (push && empty)) age_d = '0;
      else if (!empty && (age_q < AGE_MAX)) age_d = age_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
      if (!nRST) age_q <= '0;
      else       age_q <= age_d;
    end

    assign aged = (age_q >= AGE_MAX);
  end

  always_comb begin
    err_d  = err_q
           | (request_say__ENA && request_say2__ENA)
           | (any_ena && full);
    leds_d = request_setLeds__ENA ? request_setLeds_v : leds_q;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      err_q  <= 1'b0;
      leds_q <= '0;
    end else begin
      err_q  <= err_d;
      leds_q <= leds_d;
    end
  end

  assign err  = err_q;
  assign leds = leds_q;

endmodule

// File: tb/tb_echo_queue.sv
// Scoreboard bench for echo_queue: one instance with DELAY=1, one with DELAY=0.
module tb_echo_queue;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] qa[$];
  logic [32:0] qb[$];

  logic        a_say_ena, a_say_rdy, a_say2_ena, a_say2_rdy, a_led_ena, a_led_rdy;
  logic [31:0] a_say_v, a_heard_v;
  logic [15:0] a_say2_a, a_say2_b, a_heard2_a, a_heard2_b;
  logic [7:0]  a_led_v, a_leds;
  logic        a_heard_ena, a_heard_rdy, a_heard2_ena, a_heard2_rdy, a_err;
  logic [2:0]  a_count;

  logic        b_say_ena, b_say_rdy, b_say2_ena, b_say2_rdy, b_led_ena, b_led_rdy;
  logic [31:0] b_say_v, b_heard_v;
  logic [15:0] b_say2_a, b_say2_b, b_heard2_a, b_heard2_b;
  logic [7:0]  b_led_v, b_leds;
  logic        b_heard_ena, b_heard_rdy, b_heard2_ena, b_heard2_rdy, b_err;
  logic [2:0]  b_count;

  echo_queue #(.DEPTH(4), .DATA_W(32), .DELAY(1)) u_a (
    .CLK(CLK), .nRST(nRST),
    .request_say__ENA(a_say_ena), .request_say_v(a_say_v), .request_say__RDY(a_say_rdy),
    .request_say2__ENA(a_say2_ena), .request_say2_a(a_say2_a), .request_say2_b(a_say2_b),
    .request_say2__RDY(a_say2_rdy),
    .request_setLeds__ENA(a_led_ena), .request_setLeds_v(a_led_v), .request_setLeds__RDY(a_led_rdy),
    .indication_heard__ENA(a_heard_ena), .indication_heard_v(a_heard_v), .indication_heard__RDY(a_heard_rdy),
    .indication_heard2__ENA(a_heard2_ena), .indication_heard2_a(a_heard2_a), .indication_heard2_b(a_heard2_b),
    .indication_heard2__RDY(a_heard2_rdy),
    .leds(a_leds), .count(a_count), .err(a_err)
  );

  echo_queue #(.DEPTH(4), .DATA_W(32), .DELAY(0)) u_b (
    .CLK(CLK), .nRST(nRST),
    .request_say__ENA(b_say_ena), .request_say_v(b_say_v), .request_say__RDY(b_say_rdy),
    .request_say2__ENA(b_say2_ena), .request_say2_a(b_say2_a), .request_say2_b(b_say2_b),
    .request_say2__RDY(b_say2_rdy),
    .request_setLeds__ENA(b_led_ena), .request_setLeds_v(b_led_v), .request_setLeds__RDY(b_led_rdy),
    .indication_heard__ENA(b_heard_ena), .indication_heard_v(b_heard_v), .indication_heard__RDY(b_heard_rdy),
    .indication_heard2__ENA(b_heard2_ena), .indication_heard2_a(b_heard2_a), .indication_heard2_b(b_heard2_b),
    .indication_heard2__RDY(b_heard2_rdy),
    .leds(b_leds), .count(b_count), .err(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic clr_req();
    a_say_ena = 1'b0; a_say2_ena = 1'b0; a_led_ena = 1'b0;
    b_say_ena = 1'b0; b_say2_ena = 1'b0; b_led_ena = 1'b0;
  endtask

  always @(negedge CLK) begin
    logic [32:0] got;
    if (nRST) begin
      if (a_heard_ena || a_heard2_ena) begin
        chk("A_excl", 64'(a_heard_ena & a_heard2_ena), 64'd0);
        got = a_heard_ena ? {1'b0, a_heard_v} : {1'b1, a_heard2_b, a_heard2_a};
        if (qa.size() == 0) chk("A_spurious", 64'(got), 64'h1_0000_0000_0);
        else chk("A_emit", 64'(got), 64'(qa.pop_front()));
      end
      chk("A_cnt_max", 64'(a_count > 3'd4), 64'd0);
    end
  end

  always @(negedge CLK) begin
    logic [32:0] got;
    if (nRST) begin
      if (b_heard_ena || b_heard2_ena) begin
        chk("B_excl", 64'(b_heard_ena & b_heard2_ena), 64'd0);
        got = b_heard_ena ? {1'b0, b_heard_v} : {1'b1, b_heard2_b, b_heard2_a};
        if (qb.size() == 0) chk("B_spurious", 64'(got), 64'h1_0000_0000_0);
        else chk("B_emit", 64'(got), 64'(qb.pop_front()));
      end
      chk("B_cnt_max", 64'(b_count > 3'd4), 64'd0);
    end
  end

  initial begin
    logic [1:0] pat [5];
    logic [2:0] cnt_exp [5];
    clr_req();
    a_say_v = '0; a_say2_a = '0; a_say2_b = '0; a_led_v = '0;
    b_say_v = '0; b_say2_a = '0; b_say2_b = '0; b_led_v = '0;
    a_heard_rdy = 1'b1; a_heard2_rdy = 1'b1;
    b_heard_rdy = 1'b1; b_heard2_rdy = 1'b1;

    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    smp();
    chk("rst_cnt", 64'(a_count), 64'd0);
    chk("rst_ena", 64'({a_heard_ena, a_heard2_ena}), 64'd0);
    chk("rst_rdy", 64'({a_say_rdy, a_say2_rdy, a_led_rdy}), 64'd7);
    chk("rst_err_leds", 64'({a_err, a_leds}), 64'd0);
    chk("rst_b_rdy", 64'({b_say_rdy, b_say2_rdy, b_count}), 64'h18);

    // Single say through DELAY=1: emits two cycles after the call.
    step(); a_say_ena = 1'b1; a_say_v = 32'h12345678; qa.push_back({1'b0, 32'h12345678});
    smp(); chk("t1_c0_cnt", 64'(a_count), 64'd0); chk("t1_c0_ena", 64'(a_heard_ena), 64'd0);
    step(); clr_req();
    smp(); chk("t1_c1_cnt", 64'(a_count), 64'd1); chk("t1_c1_ena", 64'(a_heard_ena), 64'd0);
    step();
    smp(); chk("t1_c2_ena", 64'(a_heard_ena), 64'd1); chk("t1_c2_v", 64'(a_heard_v), 64'h12345678);
    step();
    smp(); chk("t1_c3_ena", 64'(a_heard_ena), 64'd0); chk("t1_c3_cnt", 64'(a_count), 64'd0);

    // Fill B while downstream stalls, try an overflow, then drain.
    b_heard_rdy = 1'b0; b_heard2_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); clr_req();
      if (i == 1) begin
        b_say2_ena = 1'b1; b_say2_a = 16'h0002; b_say2_b = 16'h0003;
        qb.push_back({1'b1, 16'h0003, 16'h0002});
      end else begin
        b_say_ena = 1'b1; b_say_v = (i == 0) ? 32'd1 : 32'(i + 2);
        qb.push_back({1'b0, b_say_v});
      end
      smp();
    end
    step(); clr_req(); b_say_ena = 1'b1; b_say_v = 32'd99;
    smp();
    chk("t2_full_cnt", 64'(b_count), 64'd4);
    chk("t2_full_rdy", 64'({b_say_rdy, b_say2_rdy}), 64'd0);
    chk("t2_err_pre", 64'(b_err), 64'd0);
    pat     = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b00};
    cnt_exp = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    for (int i = 0; i < 5; i++) begin
      step(); clr_req(); b_heard_rdy = 1'b1; b_heard2_rdy = 1'b1;
      smp();
      chk("t2_ena_pat", 64'({b_heard_ena, b_heard2_ena}), 64'(pat[i]));
      chk("t2_cnt", 64'(b_count), 64'(cnt_exp[i]));
      chk("t3_rdy", 64'(b_say_rdy), (i == 0) ? 64'd0 : 64'd1);
    end
    chk("t2_err_ovf", 64'(b_err), 64'd1);

    // Simultaneous say and say2: say wins, err becomes sticky.
    step(); a_say_ena = 1'b1; a_say_v = 32'd7; a_say2_ena = 1'b1; a_say2_a = 16'd1; a_say2_b = 16'd1;
    a_led_ena = 1'b1; a_led_v = 8'h3C; qa.push_back({1'b0, 32'd7});
    smp(); chk("t4_err_c0", 64'(a_err), 64'd0);
    step(); clr_req();
    smp(); chk("t4_err_c1", 64'(a_err), 64'd1); chk("t4_cnt_c1", 64'(a_count), 64'd1);
    chk("t4_leds", 64'(a_leds), 64'h3C);
    step();
    smp(); chk("t4_heard_c2", 64'({a_heard_ena, a_heard2_ena}), 64'b10);
    step();
    smp(); chk("t4_cnt_c3", 64'(a_count), 64'd0); chk("t4_err_c3", 64'(a_err), 64'd1);
    chk("t4_heard2_c3", 64'(a_heard2_ena), 64'd0);

    // Reset flushes queued entries.
    a_heard_rdy = 1'b0; a_heard2_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); clr_req();
      if (i == 1) begin
        a_say2_ena = 1'b1; a_say2_a = 16'h00AA; a_say2_b = 16'h00BB;
      end else begin
        a_say_ena = 1'b1; a_say_v = 32'(20 + i);
      end
      smp();
    end
    step(); clr_req();
    smp(); chk("t5_cnt_pre", 64'(a_count), 64'd3);
    step(); nRST = 1'b0;
    smp();
    step(); nRST = 1'b1; qa.delete(); qb.delete();
    smp();
    chk("t5_cnt", 64'(a_count), 64'd0);
    chk("t5_ena", 64'({a_heard_ena, a_heard2_ena}), 64'd0);
    chk("t5_leds_err", 64'({a_leds, a_err}), 64'd0);
    chk("t5_b_err", 64'(b_err), 64'd0);
    a_heard_rdy = 1'b1; a_heard2_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      smp(); chk("t5_quiet", 64'({a_heard_ena, a_heard2_ena, a_count}), 64'd0);
    end

    // DELAY=0 pass-through with concurrent setLeds.
    step(); b_say_ena = 1'b1; b_say_v = 32'd10; b_led_ena = 1'b1; b_led_v = 8'hA5;
    qb.push_back({1'b0, 32'd10});
    smp(); chk("t6_c0_ena", 64'(b_heard_ena), 64'd0); chk("t6_c0_leds", 64'(b_leds), 64'd0);
    step(); b_say_v = 32'd11; b_led_ena = 1'b0; qb.push_back({1'b0, 32'd11});
    smp(); chk("t6_c1_ena", 64'(b_heard_ena), 64'd1); chk("t6_c1_v", 64'(b_heard_v), 64'd10);
    chk("t6_c1_leds", 64'(b_leds), 64'hA5); chk("t6_c1_cnt", 64'(b_count), 64'd1);
    step(); clr_req();
    smp(); chk("t6_c2_ena", 64'(b_heard_ena), 64'd1); chk("t6_c2_v", 64'(b_heard_v), 64'd11);
    step();
    smp(); chk("t6_c3_ena", 64'(b_heard_ena), 64'd0); chk("t6_c3_cnt", 64'(b_count), 64'd0);

    chk("drain", 64'(qa.size() + qb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
